// File: rtl/mdio_pkg.sv
// mdio_pkg: shared types and frame layout for the Clause 22 MDIO master.
//  mdio_state_t : frame sequencer states
//  mdio_cmd_t   : captured command (write flag, PHY/register address, write data)
//  *_BIT        : first frame bit index of each field
//  bit_state()  : frame bit index -> state that owns that bit
package mdio_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_PREAMBLE, S_START, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_DONE
  } mdio_state_t;

  typedef struct packed {
    logic        write;
    logic [4:0]  phy;
    logic [4:0]  regad;
    logic [15:0] wdata;
  } mdio_cmd_t;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] ST       = 2'b01;

  localparam logic [6:0] PREAMBLE_BITS = 7'd32;
  localparam logic [6:0] FRAME_BITS    = 7'd64;

  localparam logic [5:0] ST_BIT    = 6'd32;
  localparam logic [5:0] OP_BIT    = 6'd34;
  localparam logic [5:0] PHYAD_BIT = 6'd36;
  localparam logic [5:0] REGAD_BIT = 6'd41;
  localparam logic [5:0] TA_BIT    = 6'd46;
  localparam logic [5:0] DATA_BIT  = 6'd48;
  localparam logic [5:0] LAST_BIT  = 6'd63;

  function automatic mdio_state_t bit_state(input logic [5:0] b);
    if (b < ST_BIT)         return S_PREAMBLE;
    else if (b < OP_BIT)    return S_START;
    else if (b < PHYAD_BIT) return S_OP;
    else if (b < REGAD_BIT) return S_PHYAD;
    else if (b < TA_BIT)    return S_REGAD;
    else if (b < DATA_BIT)  return S_TA;
    else                    return S_DATA;
  endfunction

endpackage

// File: rtl/mdio_master_clk_gen.sv
// mdio_clk_gen: MDC divider. Each MDC half-period is CLK_DIV clk cycles.
//  clk, rst_n : system clock, async active-low reset
//  en         : busy; when low the divider and mdc are held at 0 so every
//               frame starts phase-aligned with mdc low
//  mdc        : management clock (registered)
//  rise_tick  : first clk cycle mdc is high (MDIO input sample cycle)
//  fall_tick  : last clk cycle mdc is high; the edge ending it starts the next bit
module mdio_clk_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic mdc,
  output logic rise_tick,
  output logic fall_tick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (cnt == LAST) begin
      cnt <= '0;
      mdc <= ~mdc;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign rise_tick = en && mdc && (cnt == '0);
  assign fall_tick = en && mdc && (cnt == LAST);

endmodule

// File: rtl/mdio_master.sv
// mdio_master: IEEE 802.3 Clause 22 MDIO master, one read/write per command.
//  clk, rst_n       : 125 MHz system clock, async active-low reset
//  cmd_valid/ready  : command handshake; ready only while idle
//  cmd_write        : 1 = write, 0 = read
//  cmd_phy_addr/reg_addr/wdata : frame fields
//  rsp_valid        : one-cycle completion pulse
//  rsp_rdata/rsp_err: read data (0 after write), turnaround error; held to next rsp_valid
//  mdc, mdio_o, mdio_oe, mdio_i : MDIO pins (tristate buffer is external)
module mdio_master
  import mdio_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phy_addr,
  input  logic [4:0]  cmd_reg_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);
  mdio_state_t state, nxt_state;
  mdio_cmd_t   cmd_q;
  logic [5:0]  bit_cnt, nb, pidx, ridx;
  logic [15:0] sr;
  logic        ta_err, busy, accept, last_bit, rise_tick, fall_tick;
  logic        nxt_o, nxt_oe;
  logic [1:0]  op;

  assign busy     = (state != S_IDLE) && (state != S_DONE);
  assign accept   = cmd_valid && (state == S_IDLE);
  assign last_bit = (bit_cnt == LAST_BIT);

  mdio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (busy),
    .mdc       (mdc),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt_state;
  end

  // next state: bit boundaries are the only transition points while busy
  always_comb begin
    nxt_state = state;
    case (state)
      S_IDLE:  if (cmd_valid) nxt_state = S_PREAMBLE;
      S_DONE:  nxt_state = S_IDLE;
      default: if (fall_tick) nxt_state = last_bit ? S_DONE : bit_state(bit_cnt + 6'd1);
    endcase
  end

  // outputs: MDIO value/enable for the bit about to start (nb), plus handshake flags
  always_comb begin
    nb     = accept ? 6'd0 : bit_cnt + 6'd1;
    pidx   = 6'd40 - nb;
    ridx   = 6'd45 - nb;
    op     = cmd_q.write ? OP_WRITE : OP_READ;
    nxt_o  = 1'b1;
    nxt_oe = 1'b1;
    case (nxt_state)
      S_PREAMBLE: nxt_o = 1'b1;
      S_START:    nxt_o = nb[0] ? ST[0] : ST[1];
      S_OP:       nxt_o = nb[0] ? op[0] : op[1];
      S_PHYAD:    nxt_o = cmd_q.phy[pidx[2:0]];
      S_REGAD:    nxt_o = cmd_q.regad[ridx[2:0]];
      // write drives TA as 1,0; read releases the line from TA onward
      S_TA:       if (cmd_q.write) nxt_o = ~nb[0]; else nxt_oe = 1'b0;
      S_DATA:     if (cmd_q.write) nxt_o = sr[15]; else nxt_oe = 1'b0;
      default:    nxt_oe = 1'b0;
    endcase
    cmd_ready = (state == S_IDLE);
    rsp_valid = (state == S_DONE);
  end

  // datapath: one shift register serves write data out and read data in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q     <= '0;
      bit_cnt   <= '0;
      sr        <= '0;
      ta_err    <= 1'b0;
      mdio_o    <= 1'b1;
      mdio_oe   <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      cmd_q   <= '{write: cmd_write, phy: cmd_phy_addr, regad: cmd_reg_addr, wdata: cmd_wdata};
      bit_cnt <= '0;
      sr      <= cmd_write ? cmd_wdata : 16'h0000;
      ta_err  <= 1'b0;
      mdio_o  <= nxt_o;
      mdio_oe <= nxt_oe;
    end else if (busy) begin
      if (rise_tick && !cmd_q.write) begin
        if (state == S_TA && bit_cnt[0]) ta_err <= mdio_i;
        if (state == S_DATA)             sr     <= {sr[14:0], mdio_i};
      end
      if (fall_tick) begin
        bit_cnt <= bit_cnt + 6'd1;
        mdio_o  <= nxt_o;
        mdio_oe <= nxt_oe;
        if (cmd_q.write && nxt_state == S_DATA) sr <= {sr[14:0], 1'b0};
        if (last_bit) begin
          // with CLK_DIV=1 the final sample lands on this same edge
          rsp_rdata <= cmd_q.write ? 16'h0000 : (rise_tick ? {sr[14:0], mdio_i} : sr);
          rsp_err   <= ~cmd_q.write & ta_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: directed bench for mdio_master, CLK_DIV=2 (dut2) and CLK_DIV=1 (dut1).
module tb_mdio_master;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cv2 = 1'b0, cv1 = 1'b0, sel = 1'b0;
  logic        cmd_write = 1'b0, mdio_i = 1'b1;
  logic [4:0]  cmd_phy = '0, cmd_reg = '0;
  logic [15:0] cmd_wdata = '0;
  logic        rdy2, rv2, er2, mdc2, o2, oe2, rdy1, rv1, er1, mdc1, o1, oe1;
  logic [15:0] rd2, rd1;
  logic        rdy_s, rv_s, er_s, mdc_s, o_s, oe_s;
  logic [15:0] rd_s;
  int          n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  mdio_master #(.CLK_DIV(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cv2), .cmd_ready(rdy2), .cmd_write(cmd_write),
    .cmd_phy_addr(cmd_phy), .cmd_reg_addr(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_err(er2),
    .mdc(mdc2), .mdio_o(o2), .mdio_oe(oe2), .mdio_i(mdio_i));

  mdio_master #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cv1), .cmd_ready(rdy1), .cmd_write(cmd_write),
    .cmd_phy_addr(cmd_phy), .cmd_reg_addr(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(er1),
    .mdc(mdc1), .mdio_o(o1), .mdio_oe(oe1), .mdio_i(mdio_i));

  assign rdy_s = sel ? rdy1 : rdy2;
  assign rv_s  = sel ? rv1  : rv2;
  assign er_s  = sel ? er1  : er2;
  assign mdc_s = sel ? mdc1 : mdc2;
  assign o_s   = sel ? o1   : o2;
  assign oe_s  = sel ? oe1  : oe2;
  assign rd_s  = sel ? rd1  : rd2;

  // Present a command on the selected DUT; it is taken at the next edge.
  task automatic issue(input logic wr, input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] wd);
    cmd_write = wr; cmd_phy = pa; cmd_reg = ra; cmd_wdata = wd;
    if (sel) cv1 = 1'b1; else cv2 = 1'b1;
  endtask

  // Follow one frame from the accept edge to the idle cycle after rsp_valid.
  // Records mdio_o/mdio_oe at each mdc rise (bit k -> bits[63-k]) and plays a PHY.
  task automatic observe_frame(input bit hold, input bit phy_on, input logic [15:0] phy_data,
                               output logic [63:0] bits, output logic [63:0] oeb, output int lat,
                               output logic [15:0] rd, output logic er, output int rdy_bad,
                               output logic rdy_after, output logic mdc_after, output logic acc_rdy);
    int rises, idx;
    logic prev;
    acc_rdy = rdy_s;
    @(posedge clk); #1;
    if (!hold) begin cv2 = 1'b0; cv1 = 1'b0; end
    rises = 0; prev = 1'b0; lat = -1; rdy_bad = 0; bits = '0; oeb = '0; rd = 16'h0; er = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      if (cyc > 1) begin @(posedge clk); #1; end
      if (!prev && mdc_s && rises < 64) begin
        bits[63-rises] = o_s; oeb[63-rises] = oe_s; rises++;
      end
      prev = mdc_s;
      idx = mdc_s ? rises - 1 : rises;
      if (phy_on && idx == 47) mdio_i = 1'b0;
      else if (phy_on && idx >= 48 && idx <= 63) mdio_i = phy_data[63-idx];
      else mdio_i = 1'b1;
      if (rdy_s !== 1'b0) rdy_bad++;
      if (rv_s === 1'b1) begin lat = cyc; rd = rd_s; er = er_s; break; end
    end
    mdio_i = 1'b1;
    @(posedge clk); #1;
    rdy_after = rdy_s; mdc_after = mdc_s;
  endtask

  logic [63:0] bits, oeb;
  int          lat, rdy_bad;
  logic [15:0] rd;
  logic        er, rdy_after, mdc_after, acc_rdy;
  localparam logic [63:0] WR_1140 = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd1, 5'd0, 2'b10, 16'h1140};
  localparam logic [45:0] RD_HDR  = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd1, 5'd2};

  task automatic test_reset();
    int mdc_hi;
    rst_n = 1'b0; #12;
    n_cmp++;
    if ({mdc2, oe2, o2, rdy2, rv2, rd2, er2} !== {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0}) begin
      n_bad++; $display("FAIL reset_state2 got mdc=%b oe=%b o=%b rdy=%b rv=%b rd=%h er=%b want 0 0 1 1 0 0000 0",
                        mdc2, oe2, o2, rdy2, rv2, rd2, er2);
    end
    n_cmp++;
    if ({mdc1, oe1, o1, rdy1, rv1, rd1, er1} !== {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0}) begin
      n_bad++; $display("FAIL reset_state1 got mdc=%b oe=%b o=%b rdy=%b rv=%b rd=%h er=%b want 0 0 1 1 0 0000 0",
                        mdc1, oe1, o1, rdy1, rv1, rd1, er1);
    end
    @(negedge clk); rst_n = 1'b1;
    mdc_hi = 0;
    repeat (10) begin @(posedge clk); #1; if (mdc1 || mdc2) mdc_hi++; end
    n_cmp++;
    if (mdc_hi != 0) begin n_bad++; $display("FAIL idle_mdc got %0d high cycles want 0", mdc_hi); end
  endtask

  task automatic test_write();
    sel = 1'b0;
    issue(1'b1, 5'd1, 5'd0, 16'h1140);
    observe_frame(1'b0, 1'b0, 16'h0, bits, oeb, lat, rd, er, rdy_bad, rdy_after, mdc_after, acc_rdy);
    n_cmp++; if (bits !== WR_1140) begin n_bad++; $display("FAIL wr_bits got %h want %h", bits, WR_1140); end
    n_cmp++; if (oeb !== {64{1'b1}}) begin n_bad++; $display("FAIL wr_oe got %h want all ones", oeb); end
    n_cmp++; if (lat !== 257) begin n_bad++; $display("FAIL wr_latency got %0d want 257", lat); end
    n_cmp++; if (rd !== 16'h0000) begin n_bad++; $display("FAIL wr_rdata got %h want 0000", rd); end
    n_cmp++; if (rdy_bad != 0 || rdy_after !== 1'b1) begin
      n_bad++; $display("FAIL wr_ready got busy_ready=%0d after=%b want 0 1", rdy_bad, rdy_after); end
  endtask

  task automatic test_read();
    sel = 1'b0;
    issue(1'b0, 5'd1, 5'd2, 16'hDEAD);
    observe_frame(1'b0, 1'b1, 16'h0141, bits, oeb, lat, rd, er, rdy_bad, rdy_after, mdc_after, acc_rdy);
    n_cmp++; if (bits[63:18] !== RD_HDR) begin n_bad++; $display("FAIL rd_hdr got %h want %h", bits[63:18], RD_HDR); end
    n_cmp++; if (oeb !== {{46{1'b1}}, 18'h0}) begin n_bad++; $display("FAIL rd_oe got %h want %h", oeb, {{46{1'b1}}, 18'h0}); end
    n_cmp++; if (rd !== 16'h0141 || er !== 1'b0) begin
      n_bad++; $display("FAIL rd_data got %h err=%b want 0141 err=0", rd, er); end
    n_cmp++; if (lat !== 257) begin n_bad++; $display("FAIL rd_latency got %0d want 257", lat); end
  endtask

  task automatic test_no_phy();
    sel = 1'b0;
    issue(1'b0, 5'd7, 5'd3, 16'h0);
    observe_frame(1'b0, 1'b0, 16'h0, bits, oeb, lat, rd, er, rdy_bad, rdy_after, mdc_after, acc_rdy);
    n_cmp++; if (rd !== 16'hFFFF || er !== 1'b1) begin
      n_bad++; $display("FAIL nophy got %h err=%b want ffff err=1", rd, er); end
    // a later write must clear both response fields
    issue(1'b1, 5'd2, 5'd9, 16'h5A5A);
    observe_frame(1'b0, 1'b0, 16'h0, bits, oeb, lat, rd, er, rdy_bad, rdy_after, mdc_after, acc_rdy);
    n_cmp++; if (rd !== 16'h0000 || er !== 1'b0) begin
      n_bad++; $display("FAIL wr_after_err got %h err=%b want 0000 err=0", rd, er); end
    n_cmp++; if (bits[15:0] !== 16'h5A5A) begin n_bad++; $display("FAIL wr_data2 got %h want 5a5a", bits[15:0]); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp2;
    sel = 1'b0;
    issue(1'b1, 5'd3, 5'd4, 16'hA5A5);
    observe_frame(1'b1, 1'b0, 16'h0, bits, oeb, lat, rd, er, rdy_bad, rdy_after, mdc_after, acc_rdy);
    n_cmp++; if (rdy_bad != 0 || lat !== 257) begin
      n_bad++; $display("FAIL b2b_first got busy_ready=%0d lat=%0d want 0 257", rdy_bad, lat); end
    n_cmp++; if (rdy_after !== 1'b1 || mdc_after !== 1'b0) begin
      n_bad++; $display("FAIL b2b_idle got ready=%b mdc=%b want 1 0", rdy_after, mdc_after); end
    cmd_write = 1'b0; cmd_phy = 5'd5; cmd_reg = 5'd6;
    observe_frame(1'b0, 1'b1, 16'hBEEF, bits, oeb, lat, rd, er, rdy_bad, rdy_after, mdc_after, acc_rdy);
    exp2 = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'd5, 5'd6, 18'h0};
    n_cmp++; if (acc_rdy !== 1'b1 || lat !== 257) begin
      n_bad++; $display("FAIL b2b_second_accept got ready=%b lat=%0d want 1 257", acc_rdy, lat); end
    n_cmp++; if (bits[63:18] !== exp2[63:18] || rd !== 16'hBEEF || er !== 1'b0) begin
      n_bad++; $display("FAIL b2b_second got hdr=%h rd=%h err=%b want %h beef 0", bits[63:18], rd, er, exp2[63:18]); end
  endtask

  task automatic test_reset_mid_frame();
    int seen;
    sel = 1'b0;
    issue(1'b1, 5'd1, 5'd0, 16'h1140);
    @(posedge clk); #1; cv2 = 1'b0;
    repeat (80) @(posedge clk);
    #3; rst_n = 1'b0; #1;
    n_cmp++;
    if ({mdc2, oe2, o2, rdy2, rv2} !== {1'b0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL midreset got mdc=%b oe=%b o=%b rdy=%b rv=%b want 0 0 1 1 0", mdc2, oe2, o2, rdy2, rv2);
    end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (300) begin @(posedge clk); #1; if (rv2 || mdc2) seen++; end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL midreset_quiet got %0d active cycles want 0", seen); end
    issue(1'b0, 5'd1, 5'd2, 16'h0);
    observe_frame(1'b0, 1'b1, 16'h0141, bits, oeb, lat, rd, er, rdy_bad, rdy_after, mdc_after, acc_rdy);
    n_cmp++; if (rd !== 16'h0141 || er !== 1'b0 || lat !== 257) begin
      n_bad++; $display("FAIL midreset_read got %h err=%b lat=%0d want 0141 0 257", rd, er, lat); end
  endtask

  task automatic test_clk_div1();
    sel = 1'b1;
    issue(1'b1, 5'd1, 5'd0, 16'h1140);
    observe_frame(1'b0, 1'b0, 16'h0, bits, oeb, lat, rd, er, rdy_bad, rdy_after, mdc_after, acc_rdy);
    n_cmp++; if (bits !== WR_1140) begin n_bad++; $display("FAIL div1_bits got %h want %h", bits, WR_1140); end
    n_cmp++; if (lat !== 129 || rd !== 16'h0) begin
      n_bad++; $display("FAIL div1_latency got %0d rd=%h want 129 0000", lat, rd); end
    issue(1'b0, 5'd1, 5'd2, 16'h0);
    observe_frame(1'b0, 1'b1, 16'h8001, bits, oeb, lat, rd, er, rdy_bad, rdy_after, mdc_after, acc_rdy);
    n_cmp++; if (rd !== 16'h8001 || er !== 1'b0 || lat !== 129) begin
      n_bad++; $display("FAIL div1_read got %h err=%b lat=%0d want 8001 0 129", rd, er, lat); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_no_phy();
    test_back_to_back();
    test_reset_mid_frame();
    test_clk_div1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
